i2s_rx: RTL

- Serial-to-parallel I2S receiver; the consumer-side counterpart of the team's I2S transmitter.
- Takes sclk, lrclk and sdata from an I2S link, with the MSB arriving one sclk after each lrclk transition.
- Delivers left/right sample pairs as parallel words with a one-cycle valid strobe.
- Measures the channel word length, so the design needs no prescaler input.

---
 rtl/i2s_rx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/i2s_rx.sv
// I2S receiver: turns an sclk/lrclk/sdata link into parallel left/right
// sample pairs with a one-cycle valid strobe and a measured word length.
//
// Ports:
//   sclk       - bit clock, all logic on its rising edge
//   rst        - synchronous active-high reset
//   lrclk      - word select, 0 = left, 1 = right
//   sdata      - serial data, MSB first, MSB one sclk after each lrclk change
//   left_chan  - last completed left word (left-justified, LSB-truncated)
//   right_chan - last completed right word (left-justified, LSB-truncated)
//   valid      - one-cycle pulse when left_chan/right_chan update as a pair
//   word_bits  - measured bit count of the last right word (saturating)
//   len_err    - left/right bit counts differed; meaningful while valid=1
module i2s_rx #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             lrclk,
    input  logic             sdata,
    output logic [WIDTH-1:0] left_chan,
    output logic [WIDTH-1:0] right_chan,
    output logic             valid,
    output logic [CNT_W-1:0] word_bits,
    output logic             len_err
);

    typedef enum logic [1:0] {
        ARM,
        SYNC,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] IDX_MAX = '1;
    localparam logic [WIDTH-1:0] MSB_ONE = WIDTH'(1) << (WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic             lr_prev;
    logic [WIDTH-1:0] word;
    logic [CNT_W-1:0] idx;
    // Set once a bit has been taken at the saturated index; later bits of
    // the same word are dropped so they cannot overwrite that position.
    logic             ovf;
    logic [WIDTH-1:0] left_hold;
    logic [CNT_W-1:0] left_len;
    logic             have_left;

    logic             edge_det;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] word_cur;
    logic [CNT_W-1:0] word_len;

    assign edge_det = lrclk ^ lr_prev;

    // Shifting past the LSB yields zero, which gives the LSB truncation
    // for words longer than WIDTH without a separate range check.
    assign bit_mask = (sdata && !ovf) ? (MSB_ONE >> idx) : '0;
    assign word_cur = word | bit_mask;

    // Length of a word ending on this sample, saturating at IDX_MAX.
    assign word_len = (ovf || idx == IDX_MAX) ? IDX_MAX
                                              : idx + CNT_W'(1);

    always_ff @(posedge sclk) begin
        if (rst) begin
            state <= ARM;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ARM:     state_nx = SYNC;
            SYNC:    if (edge_det) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = ARM;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            lr_prev    <= 1'b0;
            word       <= '0;
            idx        <= '0;
            ovf        <= 1'b0;
            left_hold  <= '0;
            left_len   <= '0;
            have_left  <= 1'b0;
            left_chan  <= '0;
            right_chan <= '0;
            valid      <= 1'b0;
            word_bits  <= '0;
            len_err    <= 1'b0;
        end else begin
            lr_prev <= lrclk;
            valid   <= 1'b0;
            if (state == RUN) begin
                if (edge_det) begin
                    word <= '0;
                    idx  <= '0;
                    ovf  <= 1'b0;
                    if (!lr_prev) begin
                        left_hold <= word_cur;
                        left_len  <= word_len;
                        have_left <= 1'b1;
                    end else if (have_left) begin
                        left_chan  <= left_hold;
                        right_chan <= word_cur;
                        word_bits  <= word_len;
                        len_err    <= (left_len != word_len);
                        valid      <= 1'b1;
                        have_left  <= 1'b0;
                    end
                end else begin
                    word <= word_cur;
                    if (idx == IDX_MAX) begin
                        ovf <= 1'b1;
                    end else begin
                        idx <= idx + CNT_W'(1);
                    end
                end
            end else if (state == SYNC && edge_det) begin
                // Lock point: the partial word in flight is thrown away.
                word      <= '0;
                idx       <= '0;
                ovf       <= 1'b0;
                have_left <= 1'b0;
            end
        end
    end

endmodule
